fib_datapath: RTL
=================

FIB_DATAPATH -- requirements
Module: fib_datapath

Interface
REQ-001 Parameter DATA_W, default 32, width of Fibonacci value registers and fib_out.
REQ-002 Parameter IDX_W, default 6, width of n_in and idx.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  capture n_in, restart the sequence.
REQ-006 n_in  input  IDX_W  target index n; sampled only when load=1.
REQ-007 cnt_en  input  1  advance one Fibonacci step per cycle while high in RUN.
REQ-008 done  output  1  registered; high while state=DONE.
REQ-009 fib_out  output  DATA_W  current F(idx), taken from register a.
REQ-010 idx  output  IDX_W  number of steps taken since last load.
REQ-011 ovf  output  1  sticky overflow flag; present only when FIB_OVF_DET_EN is defined.

Function
REQ-012 The block SHALL hold registers a=F(idx), b=F(idx+1), idx, target, and a state register with states IDLE, RUN, DONE.
REQ-013 load=1 (any state): a<=0, b<=1, idx<=0, target<=n_in; next state RUN if n_in!=0, DONE if n_in==0.
REQ-014 load SHALL take priority over cnt_en in the same cycle; that cnt_en is discarded.
REQ-015 RUN with cnt_en=1, load=0: a<=b, b<=a+b truncated modulo 2^DATA_W, idx<=idx+1.
REQ-016 RUN step where idx+1==target: next state DONE on the same edge; done rises one cycle after the n-th sampled cnt_en.
REQ-017 RUN with cnt_en=0: all registers hold; gaps in cnt_en SHALL NOT change the result.
REQ-018 IDLE and DONE SHALL ignore cnt_en; a, b, idx and fib_out hold.
REQ-019 DONE SHALL persist until load or rst; fib_out=F(target) mod 2^DATA_W while done=1.
REQ-020 Total latency from load to done SHALL equal n sampled cnt_en cycles plus one edge (n=0: one edge).
REQ-021 idx SHALL never exceed target; no wrap-around of idx is possible.
REQ-022 done SHALL be usable directly as the rdy_out of the upstream control FSM; cnt_en is driven by that FSM.

Reset
REQ-023 rst=1 SHALL asynchronously force state=IDLE, a=0, b=1, idx=0, target=0, done=0, ovf=0.
REQ-024 Reset asserted mid-RUN SHALL abandon the computation; no output retains prior values after release.
REQ-025 After rst deassertion the block SHALL remain in IDLE until load=1.

Configuration
REQ-026 Macro FIB_OVF_DET_EN defined: internal flag b_wrap is set on carry-out of a+b; ovf sets when a is loaded from b while b_wrap=1 (i.e. fib_out no longer exact); ovf and b_wrap clear on load and rst.
REQ-027 Macro FIB_OVF_DET_EN undefined: ovf port, b_wrap and carry logic SHALL be absent; arithmetic stays modulo 2^DATA_W.

Verification
REQ-028 rst pulse, load n_in=10, cnt_en held high -> done=1 after 10 steps, fib_out=55, idx=10.
REQ-029 load n_in=0 -> done=1 next cycle, fib_out=0, idx=0; subsequent cnt_en pulses change nothing.
REQ-030 load n_in=7, cnt_en toggled 1,0,0,1,... (7 high cycles total) -> fib_out=13, done only after 7th high cycle.
REQ-031 load n_in=20, after 5 steps assert load n_in=6 with cnt_en=1 -> restart, idx=0 next cycle, final fib_out=8.
REQ-032 load n_in=12, rst asserted asynchronously after 4 steps -> immediate state IDLE, fib_out=0, done=0; held steady until new load.
REQ-033 DATA_W=8, FIB_OVF_DET_EN defined: n_in=13 -> fib_out=233, ovf=0; n_in=14 -> fib_out=121 (377 mod 256), ovf=1.

Source files
------------

// File: rtl/fib_datapath.sv
// fib_datapath: iterative Fibonacci F(n) engine; optional sticky overflow flag under FIB_OVF_DET_EN
module fib_datapath #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              load,
  input  logic [IDX_W-1:0]  n_in,
  input  logic              cnt_en,
  output logic              done,
  output logic [DATA_W-1:0] fib_out,
`ifdef FIB_OVF_DET_EN
  output logic              ovf,
`endif
  output logic [IDX_W-1:0]  idx
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] a, b, sum;
  logic [IDX_W-1:0] target;
  logic step;
  assign step = state == RUN && cnt_en && !load;
  assign fib_out = a;
`ifdef FIB_OVF_DET_EN
  logic carry, b_wrap;
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
  // b_wrap marks b as inexact; once that b moves into a, fib_out is inexact for good
  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      b_wrap <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      b_wrap <= 1'b0;
      ovf <= 1'b0;
    end else if (step) begin
      b_wrap <= b_wrap | carry;
      ovf <= ovf | b_wrap;
    end
`else
  assign sum = a + b;
`endif
  // next state: load restarts from anywhere, last step of RUN finishes
  always_comb begin
    state_nxt = state;
    state_nxt = load ? (n_in == '0 ? DONE : RUN)
              : (step && idx + IDX_W'(1) == target) ? DONE : state;
  end
  // state, done flag and Fibonacci pair registers
  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      a <= '0;
      b <= DATA_W'(1);
      idx <= '0;
      target <= '0;
    end else begin
      state <= state_nxt;
      done <= state_nxt == DONE;
      if (load) begin
        a <= '0;
        b <= DATA_W'(1);
        idx <= '0;
        target <= n_in;
      end else if (step) begin
        a <= b;
        b <= sum;
        idx <= idx + IDX_W'(1);
      end
    end
endmodule
